// File: rtl/rotate_arbiter.sv
// rotate_arbiter
//
// Round-robin arbiter and sequencer that shares one external 32-bit right
// rotator among NREQ requesters. The rotator registers din one cycle before
// it consumes the amount, so a granted request flows through two tracking
// stages (s1: din captured, amount being applied; s2: rotator output valid)
// before the tagged result lands in a small show-ahead FIFO.
//
// Ports
//   clock, reset  : sole clock; synchronous active-high reset
//   req           : per-requester request, held until granted
//   req_amount    : 5-bit rotate amount per requester, requester i at [5i+4:5i]
//   req_data      : 32-bit word per requester, requester i at [32i+31:32i]
//   gnt           : one-hot combinational grant; request consumed this cycle
//   rot_din       : rotator data input (winner data in grant cycle, else 0)
//   rot_amount    : rotator amount input (stage-1 amount, else 0)
//   rot_dout      : rotator registered output
//   res_valid/res_ready/res_id/res_data : result stream (FIFO head)
//
// Handshake: res_id/res_data are meaningful whenever res_valid is high and
// stay stable until the head is consumed; a transfer happens on a posedge
// where res_valid && res_ready are both high. res_valid never waits on
// res_ready.
//
// Flow control: a request is only granted while fewer than DEPTH results are
// buffered or in flight, so the FIFO can never overflow and a result is
// never dropped. Credits are computed from registered state only, so a pop
// frees its credit one cycle later.

module rotate_arbiter #(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [5*NREQ-1:0]    req_amount,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [31:0]          rot_din,
    output logic [4:0]           rot_amount,
    input  logic [31:0]          rot_dout,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [1:0]           res_id,
    output logic [31:0]          res_data
);

    localparam int IW  = $clog2(NREQ);      // requester ID width
    localparam int PW  = $clog2(DEPTH);     // FIFO pointer width
    localparam int CW  = $clog2(DEPTH + 3); // holds count + two in-flight bits

    // Round-robin pointer: the most recent winner
    logic [IW-1:0]   last;

    // Pipeline tracking for the external rotator
    logic            s1_valid;
    logic [IW-1:0]   s1_id;
    logic [4:0]      s1_amount;
    logic            s2_valid;
    logic [IW-1:0]   s2_id;

    // Result FIFO
    logic [31:0]     mem_data [DEPTH];
    logic [IW-1:0]   mem_id   [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    // Arbitration
    logic [CW-1:0]   credits;
    logic            can_grant;
    logic            found;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   win;
    logic            grant;
    logic [4:0]      win_amount;
    logic            push;
    logic            pop;

    assign credits   = count + CW'(s1_valid) + CW'(s2_valid);
    assign can_grant = !reset && (credits < CW'(DEPTH));

    // Search starts one past the last winner; IW-bit addition wraps mod NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = last + IW'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign grant = found && can_grant;

    always_comb begin
        gnt = '0;
        if (grant) begin
            gnt[win] = 1'b1;
        end
    end

    assign win_amount = req_amount[win*5 +: 5];
    assign rot_din    = grant ? req_data[win*32 +: 32] : 32'd0;
    assign rot_amount = s1_valid ? s1_amount : 5'd0;

    assign res_valid = !reset && (count != '0);
    assign res_id    = mem_id[rd_ptr];
    assign res_data  = mem_data[rd_ptr];

    // s2_valid marks the cycle in which rot_dout holds this request's result
    assign push = s2_valid;
    assign pop  = res_valid && res_ready;

    // Control state; reset discards everything in flight and buffered.
    always_ff @(posedge clock) begin
        if (reset) begin
            last     <= IW'(NREQ - 1);
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            s1_valid <= grant;
            s2_valid <= s1_valid;
            if (grant) begin
                last <= win;
            end
            // DEPTH is a power of two, so the pointers wrap naturally
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Datapath registers; qualified by the valid bits, so no reset needed.
    always_ff @(posedge clock) begin
        if (grant) begin
            s1_id     <= win;
            s1_amount <= win_amount;
        end
        s2_id <= s1_id;
        if (push && !reset) begin
            mem_data[wr_ptr] <= rot_dout;
            mem_id[wr_ptr]   <= s2_id;
        end
    end

endmodule

// File: tb/tb_rotate_arbiter.sv
// tb_rotate_arbiter
//
// Directed bench for rotate_arbiter. Includes a behavioural model of the
// external rotator (din registered, then amount applied into a registered
// dout). Inputs change on the falling edge; outputs are checked 1 ns later.

module tb_rotate_arbiter;

    localparam int W = 34; // {id, data}

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req;
    logic [19:0]   req_amount;
    logic [127:0]  req_data;
    logic [3:0]    gnt;
    logic [31:0]   rot_din;
    logic [4:0]    rot_amount;
    logic [31:0]   rot_dout;
    logic          res_valid;
    logic          res_ready;
    logic [1:0]    res_id;
    logic [31:0]   res_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    rotate_arbiter #(.NREQ(4), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_amount (req_amount),
        .req_data   (req_data),
        .gnt        (gnt),
        .rot_din    (rot_din),
        .rot_amount (rot_amount),
        .rot_dout   (rot_dout),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_data   (res_data)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- external rotator model ----------------
    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] a);
        logic [63:0] t;
        t = {x, x} >> a;
        return t[31:0];
    endfunction

    logic [31:0] rot_din_q;
    always @(posedge clock) begin
        rot_din_q <= rot_din;
        rot_dout  <= ror32(rot_din_q, rot_amount);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: compare every transfer against the expected queue
    task automatic observe();
        logic [W-1:0] e;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_result", {30'd0, res_id, res_data}, {30'd0, e});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req   = 4'd0;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Hand-computed table: r0 0x000000F0>>4, r1 0x0000AB00>>8,
    // r2 0x00C00000>>16, r3 0x00000001>>1
    task automatic load_table();
        req_data   = {32'h00000001, 32'h00C00000, 32'h0000AB00, 32'h000000F0};
        req_amount = {5'd1, 5'd16, 5'd8, 5'd4};
    endtask

    logic [W-1:0] r0_res = {2'd0, 32'h0000000F};
    logic [W-1:0] r1_res = {2'd1, 32'h000000AB};
    logic [W-1:0] r2_res = {2'd2, 32'h000000C0};
    logic [W-1:0] r3_res = {2'd3, 32'h80000000};

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] rr_gnt [9];
        logic [4:0] c_amt  [3];
        rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        c_amt  = '{5'd0, 5'd31, 5'd16};

        req        = 4'hF;
        req_amount = '0;
        req_data   = '0;
        res_ready  = 1'b1;

        // Reset state: no grant or result even with all requests up
        repeat (2) @(negedge clock);
        #1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_rot_din", 64'(rot_din), 64'd0);

        // ---- Single request: 0x80000001 ror 1 -> 0xC0000000 ----
        @(negedge clock);
        reset      = 1'b0;
        req        = 4'b0001;
        req_data   = {96'd0, 32'h80000001};
        req_amount = {15'd0, 5'd1};
        #1;
        check("single_gnt", 64'(gnt), 64'b0001);
        check("single_rot_din", 64'(rot_din), 64'h80000001);
        @(negedge clock);
        req = 4'd0;
        #1;
        check("single_gnt_t1", 64'(gnt), 64'd0);
        check("single_rot_amount_t1", 64'(rot_amount), 64'd1);
        check("single_valid_t1", 64'(res_valid), 64'd0);
        @(negedge clock);
        #1;
        check("single_valid_t2", 64'(res_valid), 64'd0);
        check("single_rot_amount_t2", 64'(rot_amount), 64'd0);
        @(negedge clock);
        #1;
        check("single_valid_t3", 64'(res_valid), 64'd1);
        check("single_id_t3", 64'(res_id), 64'd0);
        check("single_data_t3", 64'(res_data), 64'hC0000000);
        @(negedge clock);
        #1;
        check("single_valid_t4", 64'(res_valid), 64'd0);

        // ---- Round robin from reset: grants 0,1,2,3,0 ----
        do_reset();
        load_table();
        exp_q.push_back(r0_res);
        exp_q.push_back(r1_res);
        exp_q.push_back(r2_res);
        exp_q.push_back(r3_res);
        exp_q.push_back(r0_res);
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            req = (k < 5) ? 4'hF : 4'h0;
            #1;
            check($sformatf("rr_gnt_%0d", k), 64'(gnt), 64'(rr_gnt[k]));
            check($sformatf("rr_valid_%0d", k), 64'(res_valid), 64'(k >= 3 && k <= 7));
            observe();
        end
        check("rr_drained", 64'(exp_q.size()), 64'd0);

        // ---- Amount extremes on requester 1 (last is 0, r1 alone) ----
        req_data = {64'd0, 32'h12345678, 32'd0};
        exp_q.push_back({2'd1, 32'h12345678});
        exp_q.push_back({2'd1, 32'h2468ACF0});
        exp_q.push_back({2'd1, 32'h56781234});
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            req        = (k < 3) ? 4'b0010 : 4'b0000;
            req_amount = {10'd0, (k < 3) ? c_amt[k] : 5'd0, 5'd0};
            #1;
            check($sformatf("amt_gnt_%0d", k), 64'(gnt), (k < 3) ? 64'b0010 : 64'd0);
            check($sformatf("amt_valid_%0d", k), 64'(res_valid), 64'(k >= 3 && k <= 5));
            observe();
        end
        check("amt_drained", 64'(exp_q.size()), 64'd0);

        // ---- Backpressure: four grants, then hold until a pop ----
        do_reset();
        load_table();
        res_ready = 1'b0;
        exp_q.push_back(r0_res);
        exp_q.push_back(r1_res);
        exp_q.push_back(r2_res);
        exp_q.push_back(r3_res);
        exp_q.push_back(r0_res);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            req = 4'hF;
            #1;
            check($sformatf("bp_gnt_%0d", k), 64'(gnt), (k < 4) ? 64'(4'b0001 << k) : 64'd0);
            check($sformatf("bp_valid_%0d", k), 64'(res_valid), 64'(k >= 3));
            if (k >= 3) begin
                check($sformatf("bp_head_%0d", k), {30'd0, res_id, res_data}, {30'd0, r0_res});
            end
        end
        // One-cycle pop: credit is not returned in the pop cycle
        @(negedge clock);
        res_ready = 1'b1;
        #1;
        check("bp_pop_gnt", 64'(gnt), 64'd0);
        observe();
        @(negedge clock);
        res_ready = 1'b0;
        #1;
        check("bp_after_pop_gnt", 64'(gnt), 64'b0001);
        check("bp_after_pop_head", {30'd0, res_id, res_data}, {30'd0, r1_res});
        @(negedge clock);
        #1;
        check("bp_refull_gnt", 64'(gnt), 64'd0);
        check("bp_refull_head", {30'd0, res_id, res_data}, {30'd0, r1_res});
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            res_ready = 1'b1;
            req       = 4'd0;
            #1;
            check($sformatf("bp_drain_valid_%0d", k), 64'(res_valid), 64'(k < 4));
            observe();
        end
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // ---- Reset mid-flight (last is 0 here) ----
        @(negedge clock);
        req = 4'b0001;
        #1;
        check("mid_gnt_t", 64'(gnt), 64'b0001);
        @(negedge clock);
        reset = 1'b1;
        req   = 4'd0;
        #1;
        check("mid_rst_gnt", 64'(gnt), 64'd0);
        check("mid_rst_valid", 64'(res_valid), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            reset = 1'b0;
            #1;
            check($sformatf("mid_valid_t%0d", k), 64'(res_valid), 64'd0);
        end
        exp_q.push_back(r0_res);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            req = (k == 0) ? 4'hF : 4'h0;
            #1;
            check($sformatf("mid_post_gnt_%0d", k), 64'(gnt), (k == 0) ? 64'b0001 : 64'd0);
            check($sformatf("mid_post_valid_%0d", k), 64'(res_valid), 64'(k == 3));
            observe();
        end
        check("mid_drained", 64'(exp_q.size()), 64'd0);

        // ---- Simultaneous push/pop with two entries buffered ----
        do_reset();
        load_table();
        res_ready = 1'b0;
        exp_q.push_back(r0_res);
        exp_q.push_back(r1_res);
        exp_q.push_back(r2_res);
        exp_q.push_back(r3_res);
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            req       = (k < 4) ? 4'hF : 4'h0;
            res_ready = (k >= 4);
            #1;
            check($sformatf("pp_gnt_%0d", k), 64'(gnt), (k < 4) ? 64'(4'b0001 << k) : 64'd0);
            check($sformatf("pp_valid_%0d", k), 64'(res_valid), 64'(k >= 3 && k <= 7));
            observe();
        end
        check("pp_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rotate_arbiter.md
# rotate_arbiter

Round-robin arbiter and sequencer sharing one 32-bit right rotator among four requesters. Handles the rotator's split timing: `din` is registered one cycle before `amount` is applied. Tags each result with its requester ID and buffers results in a 4-entry output FIFO with ready/valid backpressure. Sits between the requesting datapaths and the rotator instance; the rotator's ports connect directly to `rot_*`.

## Interface
- `NREQ`, 4 — number of requesters (fixed; ID width 2)
- `DEPTH`, 4 — output FIFO entries; also the credit limit
- `clock`  in  1  — sole clock; all state updates on the posedge
- `reset`  in  1  — synchronous, active-high
- `req`  in  4  — request per requester; held until granted
- `req_amount`  in  20  — 5-bit rotate amount per requester; requester i uses bits [5i+4:5i]
- `req_data`  in  128  — 32-bit word per requester; requester i uses bits [32i+31:32i]
- `gnt`  out  4  — one-hot grant, combinational; the request is consumed in the same cycle
- `rot_din`  out  32  — to the rotator data input
- `rot_amount`  out  5  — to the rotator amount input
- `rot_dout`  in  32  — from the rotator registered output
- `res_valid`  out  1  — FIFO head is valid
- `res_ready`  in  1  — consumer accepts the head
- `res_id`  out  2  — requester ID of the head
- `res_data`  out  32  — rotated word at the head

## Operation
- Credit count is `fifo_count + s1_valid + s2_valid`, computed from registered values only.
- A grant is allowed only when credits < `DEPTH`.
- A pop in the current cycle does not free a credit until the next cycle.
- Arbitration is round-robin with pointer `last`:
  - Priority order starts at `last+1` (mod 4).
  - The first asserted `req` in that order wins.
  - `last` updates to the winner on each grant.
  - At most one grant per cycle.
- In the grant cycle, `rot_din` = `req_data` of the winner. With no grant, `rot_din` = 0.
- Stage 1 registers on the grant edge: `s1_valid`=1, `s1_id`, `s1_amount`.
- In the next cycle, `rot_amount` = `s1_amount` if `s1_valid`, else 0.
- Stage 2 registers: `s2_valid`, `s2_id` from stage 1.
- While `s2_valid`, the rotator result is written to the FIFO tail on that cycle's edge:
  - data = `rot_dout`
  - id = `s2_id`
- Result is `req_data` rotated right by `amount` (mod 32), i.e. `{x[a-1:0], x[31:a]}`. Amount 0 passes the data unchanged.
- FIFO:
  - Show-ahead: `res_*` reflect the head directly from storage.
  - Pop when `res_valid && res_ready`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap mod 4.
- Overflow cannot occur under the credit rule.
- Results leave in grant order.
- A non-granted requester keeps `req` high.
- Starvation bound: 3 grants to others before service.
- Reset state:
  - `s1_valid` = `s2_valid` = 0, `fifo_count` = 0, pointers = 0, `last` = 3 (requester 0 has first priority).
  - `gnt` = 0 and `res_valid` = 0 while `reset` is high.
- Reset mid-operation:
  - In-flight and buffered results are discarded.
  - Garbage in the rotator registers is ignored because the valid bits are cleared.
  - No `res_valid` for anything granted before reset.

## Timing
- Grant in cycle t. Rotator captures `din` at the end of t.
- `rot_amount` is driven during t+1. Rotator `dout` is updated at the end of t+1.
- `rot_dout` is sampled into the FIFO at the end of t+2.
- `res_valid` is high from t+3. Grant-to-result latency is 3 cycles.
- Throughput: 1 grant per cycle sustained while `res_ready`=1. Steady-state credits are 3 < 4.
- With `res_ready`=0, at most 4 grants are issued; then `gnt`=0 until a pop.
- After the first pop, the next grant is possible in the cycle after the pop.

## Test plan
- Single request: `req`=0001, data 0x80000001, amount 1 → `gnt`=0001 at t; `res_valid` at t+3 with id 0, data 0xC0000000.
- Round robin: all four `req` held from reset → grants 0,1,2,3,0 on consecutive cycles; results in that order, back-to-back, one per cycle.
- Amount extremes: data 0x12345678 with amount 0 → 0x12345678; with amount 31 → 0x2468ACF0; with amount 16 → 0x56781234.
- Backpressure: `res_ready`=0 with continuous requests → exactly 4 grants; `res_valid` held with the head unchanged. Raise `res_ready` for 1 cycle → one pop, then exactly one further grant.
- Reset mid-flight: grant at t, assert `reset` in t+1 → no `res_valid` through t+5. `last` = 3, so `req`=1111 after reset grants requester 0.
- Simultaneous push/pop: FIFO holding 2 entries, `res_ready`=1, new results arriving each cycle → `fifo_count` stable and order preserved.
